// File: rtl/digital_sensor_pkg.sv
// rtl/digital_sensor_pkg.sv - command/response codes and state encoding for command_handler
package digital_sensor_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_ADDR,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_SENSOR,
    ST_SEND_CODE,
    ST_WAIT_CODE,
    ST_SEND_VALUE,
    ST_WAIT_VALUE
  } state_t;

  localparam logic [7:0] CMD_STATUS     = 8'h00;
  localparam logic [7:0] CMD_READ_TEMP  = 8'h01;
  localparam logic [7:0] CMD_READ_HUM   = 8'h02;
  localparam logic [7:0] CMD_CONT_TEMP  = 8'h03;
  localparam logic [7:0] CMD_CONT_HUM   = 8'h04;
  localparam logic [7:0] CMD_STOP       = 8'h05;

  localparam logic [7:0] RSP_STATUS     = 8'h07;
  localparam logic [7:0] RSP_TEMP       = 8'h08;
  localparam logic [7:0] RSP_HUM        = 8'h09;
  localparam logic [7:0] RSP_STOPPED    = 8'h0A;
  localparam logic [7:0] RSP_BAD_CMD    = 8'h1E;
  localparam logic [7:0] RSP_SENSOR_ERR = 8'h1F;

  localparam logic [7:0] VAL_SENSOR_ERR = 8'h00;
  localparam logic [7:0] VAL_TIMEOUT    = 8'hFF;

  // Response code for a successful measurement of the given kind (0 temp, 1 humidity)
  function automatic logic [7:0] data_code(input logic kind);
    return kind ? RSP_HUM : RSP_TEMP;
  endfunction

endpackage

// File: rtl/command_handler_if.sv
// rtl/command_handler_if.sv - UART byte, sensor and transmit handshakes of command_handler
interface command_handler_if;
  logic       has_data;
  logic [7:0] data_received;
  logic       sensor_request;
  logic [4:0] sensor_address;
  logic       sensor_kind;
  logic       sensor_done;
  logic [7:0] sensor_data;
  logic       sensor_error;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       overrun;

  // Handler side
  modport master (
    input  has_data, data_received, sensor_done, sensor_data, sensor_error, tx_done,
    output sensor_request, sensor_address, sensor_kind, tx_start, tx_data, overrun
  );

  // UART / sensor / transmitter side
  modport slave (
    output has_data, data_received, sensor_done, sensor_data, sensor_error, tx_done,
    input  sensor_request, sensor_address, sensor_kind, tx_start, tx_data, overrun
  );
endinterface

// File: rtl/command_timer.sv
// rtl/command_timer.sv - loadable down-counter with expired flag
module command_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; counting stops at zero so expired stays asserted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/command_handler.sv
// rtl/command_handler.sv - two-byte command frame decoder driving sensor requests and UART replies
module command_handler
  import digital_sensor_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT   = 50000,
  parameter int unsigned SENSOR_TIMEOUT = 2000000,
  parameter int unsigned INTERVAL       = 10000000
) (
  input  logic                clock,
  input  logic                reset,
  command_handler_if.master   bus
);

  // Timers count down from N-1 so the expiry cycle is the N-th cycle in the waiting state
  localparam logic [31:0] BYTE_LOAD   = 32'(BYTE_TIMEOUT - 1);
  localparam logic [31:0] SENSOR_LOAD = 32'(SENSOR_TIMEOUT - 1);
  localparam logic [31:0] INT_LOAD    = 32'(INTERVAL - 1);

  state_t     r_state;
  logic [7:0] r_cmd;
  logic [4:0] r_addr;
  logic       r_continuous;
  logic       r_cont_kind;
  logic [4:0] r_cont_addr;
  logic [7:0] r_code;
  logic [7:0] r_value;

  logic w_byte_load, w_byte_en, w_byte_expired;
  logic w_sens_load, w_sens_en, w_sens_expired;
  logic w_int_load, w_int_en, w_int_expired;
  logic w_cont_cmd;
  logic w_busy;

  assign w_cont_cmd  = (r_cmd == CMD_CONT_TEMP) || (r_cmd == CMD_CONT_HUM);
  assign w_busy      = (r_state != ST_IDLE) && (r_state != ST_WAIT_ADDR);

  assign w_byte_load = (r_state == ST_IDLE) && bus.has_data;
  assign w_byte_en   = (r_state == ST_WAIT_ADDR);
  assign w_sens_load = (r_state == ST_ISSUE);
  assign w_sens_en   = (r_state == ST_WAIT_SENSOR);
  // Interval reloads on entering continuous mode and on every expiry, even when a byte wins the cycle
  assign w_int_load  = ((r_state == ST_DECODE) && w_cont_cmd) ||
                       ((r_state == ST_IDLE) && r_continuous && w_int_expired);
  assign w_int_en    = (r_state == ST_IDLE) && r_continuous && !bus.has_data;

  command_timer #(.WIDTH(32)) u_byte_timer (
    .clock(clock), .reset(reset), .i_load(w_byte_load), .i_load_value(BYTE_LOAD),
    .i_enable(w_byte_en), .o_expired(w_byte_expired)
  );

  command_timer #(.WIDTH(32)) u_sensor_timer (
    .clock(clock), .reset(reset), .i_load(w_sens_load), .i_load_value(SENSOR_LOAD),
    .i_enable(w_sens_en), .o_expired(w_sens_expired)
  );

  command_timer #(.WIDTH(32)) u_interval_timer (
    .clock(clock), .reset(reset), .i_load(w_int_load), .i_load_value(INT_LOAD),
    .i_enable(w_int_en), .o_expired(w_int_expired)
  );

  // Frame sequencing, sensor request and two-byte reply, all outputs registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state            <= ST_IDLE;
      r_cmd              <= '0;
      r_addr             <= '0;
      r_continuous       <= 1'b0;
      r_cont_kind        <= 1'b0;
      r_cont_addr        <= '0;
      r_code             <= '0;
      r_value            <= '0;
      bus.sensor_request <= 1'b0;
      bus.sensor_address <= '0;
      bus.sensor_kind    <= 1'b0;
      bus.tx_start       <= 1'b0;
      bus.tx_data        <= '0;
      bus.overrun        <= 1'b0;
    end else begin
      bus.sensor_request <= 1'b0;
      bus.tx_start       <= 1'b0;

      // A byte landing while busy is dropped; a new frame reaching DECODE clears the flag
      if (bus.has_data && w_busy) begin
        bus.overrun <= 1'b1;
      end else if (r_state == ST_DECODE) begin
        bus.overrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.has_data) begin
            r_cmd   <= bus.data_received;
            r_state <= ST_WAIT_ADDR;
          end else if (r_continuous && w_int_expired) begin
            bus.sensor_kind    <= r_cont_kind;
            bus.sensor_address <= r_cont_addr;
            r_state            <= ST_ISSUE;
          end
        end

        ST_WAIT_ADDR: begin
          if (bus.has_data) begin
            r_addr  <= bus.data_received[4:0];
            r_state <= ST_DECODE;
          end else if (w_byte_expired) begin
            r_state <= ST_IDLE;
          end
        end

        ST_DECODE: begin
          case (r_cmd)
            CMD_READ_TEMP, CMD_READ_HUM, CMD_CONT_TEMP, CMD_CONT_HUM: begin
              bus.sensor_kind    <= (r_cmd == CMD_READ_HUM) || (r_cmd == CMD_CONT_HUM);
              bus.sensor_address <= r_addr;
              if (w_cont_cmd) begin
                r_continuous <= 1'b1;
                r_cont_kind  <= (r_cmd == CMD_CONT_HUM);
                r_cont_addr  <= r_addr;
              end
              r_state <= ST_ISSUE;
            end
            CMD_STOP: begin
              r_continuous <= 1'b0;
              r_code       <= RSP_STOPPED;
              r_value      <= 8'h00;
              r_state      <= ST_SEND_CODE;
            end
            CMD_STATUS: begin
              r_code  <= RSP_STATUS;
              r_value <= {7'b0, r_continuous};
              r_state <= ST_SEND_CODE;
            end
            default: begin
              r_code  <= RSP_BAD_CMD;
              r_value <= r_cmd;
              r_state <= ST_SEND_CODE;
            end
          endcase
        end

        ST_ISSUE: begin
          bus.sensor_request <= 1'b1;
          r_state            <= ST_WAIT_SENSOR;
        end

        ST_WAIT_SENSOR: begin
          if (bus.sensor_done) begin
            if (bus.sensor_error) begin
              r_code  <= RSP_SENSOR_ERR;
              r_value <= VAL_SENSOR_ERR;
            end else begin
              r_code  <= data_code(bus.sensor_kind);
              r_value <= bus.sensor_data;
            end
            r_state <= ST_SEND_CODE;
          end else if (w_sens_expired) begin
            r_code  <= RSP_SENSOR_ERR;
            r_value <= VAL_TIMEOUT;
            r_state <= ST_SEND_CODE;
          end
        end

        ST_SEND_CODE: begin
          bus.tx_start <= 1'b1;
          bus.tx_data  <= r_code;
          r_state      <= ST_WAIT_CODE;
        end

        ST_WAIT_CODE: begin
          if (bus.tx_done) r_state <= ST_SEND_VALUE;
        end

        ST_SEND_VALUE: begin
          bus.tx_start <= 1'b1;
          bus.tx_data  <= r_value;
          r_state      <= ST_WAIT_VALUE;
        end

        ST_WAIT_VALUE: begin
          if (bus.tx_done) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_command_handler.sv
// tb/tb_command_handler.sv - randomized directed bench for command_handler with reference reply model
module tb_command_handler;

  localparam int BT  = 20;
  localparam int ST  = 100;
  localparam int INT = 300;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  command_handler_if bus ();

  command_handler #(
    .BYTE_TIMEOUT(BT), .SENSOR_TIMEOUT(ST), .INTERVAL(INT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_req    = 0;
  int n_tx     = 0;

  // Pulse counters for "no activity" checks
  always @(negedge clock) begin
    if (bus.sensor_request === 1'b1) n_req++;
    if (bus.tx_start === 1'b1) n_tx++;
  end

  // Reply expected for a successful or failed measurement
  function automatic logic [15:0] model_sensor(input bit hum, input logic [7:0] d, input bit err);
    if (err) return 16'h1F00;
    return {(hum ? 8'h09 : 8'h08), d};
  endfunction

  // Reply expected for commands that never touch the sensor
  function automatic logic [15:0] model_reply(input logic [7:0] cmd, input bit cont);
    if (cmd == 8'h05) return 16'h0A00;
    if (cmd == 8'h00) return {8'h07, 7'b0, cont};
    return {8'h1E, cmd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.has_data      = 1'b1;
    bus.data_received = b;
    @(negedge clock);
    bus.has_data      = 1'b0;
  endtask

  task automatic wait_req(input int budget, output int t);
    t = 0;
    while (bus.sensor_request !== 1'b1 && t < budget) begin
      @(negedge clock);
      t++;
    end
    chk("request_seen", {31'b0, bus.sensor_request === 1'b1}, 32'd1);
  endtask

  task automatic service(input logic [7:0] d, input bit err);
    tick($urandom_range(1, 5));
    bus.sensor_done  = 1'b1;
    bus.sensor_data  = d;
    bus.sensor_error = err;
    @(negedge clock);
    bus.sensor_done  = 1'b0;
    bus.sensor_data  = $urandom;
    bus.sensor_error = $urandom;
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp, input int budget, output int t);
    t = 0;
    while (bus.tx_start !== 1'b1 && t < budget) begin
      @(negedge clock);
      t++;
    end
    chk({tag, "_start"}, {31'b0, bus.tx_start === 1'b1}, 32'd1);
    chk({tag, "_data"}, {24'b0, bus.tx_data}, {24'b0, exp});
    tick($urandom_range(0, 3));
    chk({tag, "_held"}, {24'b0, bus.tx_data}, {24'b0, exp});
    bus.tx_done = 1'b1;
    @(negedge clock);
    bus.tx_done = 1'b0;
  endtask

  task automatic reply_frame(input logic [7:0] cmd, input logic [7:0] ab, input bit cont);
    logic [15:0] rsp;
    int t;
    rsp = model_reply(cmd, cont);
    send_byte(cmd);
    send_byte(ab);
    expect_tx("reply_code", rsp[15:8], 20, t);
    expect_tx("reply_value", rsp[7:0], 20, t);
  endtask

  task automatic read_frame(input logic [7:0] cmd, input logic [7:0] ab, input int gap,
                            input logic [7:0] d, input bit err);
    logic [15:0] rsp;
    int t;
    int n0;
    n0 = n_req;
    send_byte(cmd);
    tick(gap);
    send_byte(ab);
    wait_req(10, t);
    chk("req_address", {27'b0, bus.sensor_address}, {27'b0, ab[4:0]});
    chk("req_kind", {31'b0, bus.sensor_kind}, {31'b0, cmd == 8'h02});
    service(d, err);
    rsp = model_sensor(cmd == 8'h02, d, err);
    expect_tx("read_code", rsp[15:8], 20, t);
    expect_tx("read_value", rsp[7:0], 20, t);
    chk("one_request", n_req - n0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd, ab, d;
    logic [15:0] rsp;
    bit e;
    int t, n0, x0;

    bus.has_data = 1'b0; bus.data_received = '0;
    bus.sensor_done = 1'b0; bus.sensor_data = '0; bus.sensor_error = 1'b0;
    bus.tx_done = 1'b0;

    // Reset state
    tick(3);
    chk("rst_request", {31'b0, bus.sensor_request}, 0);
    chk("rst_address", {27'b0, bus.sensor_address}, 0);
    chk("rst_kind", {31'b0, bus.sensor_kind}, 0);
    chk("rst_tx_start", {31'b0, bus.tx_start}, 0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 0);
    chk("rst_overrun", {31'b0, bus.overrun}, 0);
    @(negedge clock) reset = 1'b1;

    // Single reads: the fixed example then random kinds/addresses/data/errors
    for (int i = 0; i < 6; i++) begin
      cmd = (i == 0) ? 8'h01 : 8'($urandom_range(1, 2));
      ab  = (i == 0) ? 8'h03 : 8'($urandom);
      d   = (i == 0) ? 8'h19 : 8'($urandom);
      e   = (i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      read_frame(cmd, ab, (i == 0) ? 0 : $urandom_range(0, 12), d, e);
    end

    // Address byte too late: first command discarded, next byte starts a new frame
    n0 = n_req; x0 = n_tx;
    send_byte(8'h02);
    tick(25);
    send_byte(8'h00);
    tick(5);
    chk("late_no_req", n_req - n0, 0);
    chk("late_no_tx", n_tx - x0, 0);
    reply_frame(8'h00, 8'h00, 1'b0);
    chk("late_no_req_after", n_req - n0, 0);

    // Sensor never answers
    send_byte(8'h02);
    send_byte(8'h01);
    wait_req(10, t);
    expect_tx("timeout_code", 8'h1F, ST + 50, t);
    chk("timeout_latency", {31'b0, (t >= ST) && (t <= ST + 3)}, 1);
    expect_tx("timeout_value", 8'hFF, 20, t);

    // Stray sensor_done in IDLE is ignored
    x0 = n_tx;
    bus.sensor_done = 1'b1;
    @(negedge clock) bus.sensor_done = 1'b0;
    tick(10);
    chk("stray_done_no_tx", n_tx - x0, 0);

    // Unknown commands and status
    reply_frame(8'h77, 8'h00, 1'b0);
    reply_frame(8'($urandom_range(6, 255)), 8'($urandom), 1'b0);
    reply_frame(8'h00, 8'($urandom), 1'b0);

    // Byte during WAIT_SENSOR sets overrun, which survives until the next frame decodes
    send_byte(8'h01);
    send_byte(8'h05);
    wait_req(10, t);
    send_byte(8'hAA);
    chk("overrun_set", {31'b0, bus.overrun}, 1);
    d = 8'($urandom);
    service(d, 1'b0);
    rsp = model_sensor(1'b0, d, 1'b0);
    expect_tx("ovr_code", rsp[15:8], 20, t);
    expect_tx("ovr_value", rsp[7:0], 20, t);
    chk("overrun_sticky", {31'b0, bus.overrun}, 1);
    reply_frame(8'h00, 8'h00, 1'b0);
    chk("overrun_cleared", {31'b0, bus.overrun}, 0);

    // Continuous humidity at address 2
    send_byte(8'h04);
    send_byte(8'h02);
    for (int k = 0; k < 3; k++) begin
      wait_req(INT + 50, t);
      if (k > 0) chk("interval_spacing", {31'b0, (t >= INT) && (t <= INT + 3)}, 1);
      chk("cont_address", {27'b0, bus.sensor_address}, 32'd2);
      chk("cont_kind", {31'b0, bus.sensor_kind}, 1);
      d = 8'($urandom);
      service(d, 1'b0);
      rsp = model_sensor(1'b1, d, 1'b0);
      expect_tx("cont_code", rsp[15:8], 20, t);
      expect_tx("cont_value", rsp[7:0], 20, t);
    end
    reply_frame(8'h00, 8'h00, 1'b1);
    wait_req(INT + 50, t);
    service(8'h33, 1'b1);
    expect_tx("cont_err_code", 8'h1F, 20, t);
    expect_tx("cont_err_value", 8'h00, 20, t);
    reply_frame(8'h05, 8'h00, 1'b1);
    n0 = n_req;
    tick(2 * INT + 100);
    chk("stopped_no_req", n_req - n0, 0);
    reply_frame(8'h00, 8'h00, 1'b0);

    // Reset while the first reply byte waits for tx_done
    send_byte(8'h00);
    send_byte(8'h00);
    t = 0;
    while (bus.tx_start !== 1'b1 && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("pre_reset_tx", {31'b0, bus.tx_start === 1'b1}, 1);
    tick(2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_tx_start", {31'b0, bus.tx_start}, 0);
    chk("mid_rst_tx_data", {24'b0, bus.tx_data}, 0);
    chk("mid_rst_request", {31'b0, bus.sensor_request}, 0);
    chk("mid_rst_address", {27'b0, bus.sensor_address}, 0);
    chk("mid_rst_kind", {31'b0, bus.sensor_kind}, 0);
    chk("mid_rst_overrun", {31'b0, bus.overrun}, 0);
    tick(2);
    reset = 1'b1;
    read_frame(8'h02, 8'($urandom), 0, 8'($urandom_range(0, 255)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/command_handler.md
COMMAND_HANDLER -- requirements
Module: command_handler

Interface
REQ-001 Parameter BYTE_TIMEOUT, default 50000: max cycles allowed between command byte and address byte.
REQ-002 Parameter SENSOR_TIMEOUT, default 2000000: max cycles to wait for sensor_done after sensor_request.
REQ-003 Parameter INTERVAL, default 10000000: cycles between automatic measurements in continuous mode.
REQ-004 clock  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 has_data  in  1  one-cycle pulse; data_received is a valid byte.
REQ-007 data_received  in  8  byte from the UART receiver.
REQ-008 sensor_request  out  1  one-cycle pulse starting a measurement.
REQ-009 sensor_address  out  5  target sensor, stable from request pulse until sensor_done.
REQ-010 sensor_kind  out  1  0 = temperature, 1 = humidity; stable like sensor_address.
REQ-011 sensor_done  in  1  one-cycle pulse; sensor_data and sensor_error valid.
REQ-012 sensor_data  in  8  measured value.
REQ-013 sensor_error  in  1  measurement failed.
REQ-014 tx_start  out  1  one-cycle pulse; tx_data is a byte to transmit.
REQ-015 tx_data  out  8  byte to the UART transmitter, held until tx_done.
REQ-016 tx_done  in  1  one-cycle pulse; transmitter finished the byte.
REQ-017 overrun  out  1  sticky: a byte arrived while busy and was dropped.

Function
REQ-018 Frame = two bytes: command, then address; address bits [7:5] SHALL be ignored.
REQ-019 Commands: 0x01 read temperature, 0x02 read humidity, 0x03 continuous temperature, 0x04 continuous humidity, 0x05 stop continuous, 0x00 status.
REQ-020 States: IDLE, WAIT_ADDR, DECODE, ISSUE, WAIT_SENSOR, SEND_CODE, WAIT_CODE, SEND_VALUE, WAIT_VALUE.
REQ-021 IDLE + has_data -> WAIT_ADDR, byte latched; WAIT_ADDR + has_data -> DECODE.
REQ-022 WAIT_ADDR with no byte for BYTE_TIMEOUT cycles -> IDLE; no response is sent.
REQ-023 DECODE: 0x01-0x04 -> ISSUE; 0x03/0x04 also set continuous flag, kind and address.
REQ-024 DECODE: 0x05 clears continuous flag and replies 0x0A,0x00; 0x00 replies 0x07,{7'b0,continuous flag}.
REQ-025 DECODE: any other command replies 0x1E,<command byte>; ISSUE/WAIT_SENSOR are skipped.
REQ-026 ISSUE SHALL pulse sensor_request exactly one cycle, then enter WAIT_SENSOR.
REQ-027 Response on sensor_done: error=0 -> 0x08 (temp) or 0x09 (humidity), then sensor_data; error=1 -> 0x1F,0x00.
REQ-028 WAIT_SENSOR expiring SENSOR_TIMEOUT without sensor_done SHALL respond 0x1F,0xFF.
REQ-029 SEND_CODE/SEND_VALUE pulse tx_start one cycle; next byte only after tx_done (WAIT_CODE/WAIT_VALUE); WAIT_VALUE + tx_done -> IDLE.
REQ-030 Continuous mode: interval counter runs in IDLE; at INTERVAL it reloads and IDLE -> ISSUE with stored kind/address.
REQ-031 has_data and interval expiry in the same IDLE cycle: the byte wins; the interval counter reloads.
REQ-032 has_data in any state other than IDLE/WAIT_ADDR: byte dropped, overrun set; cleared at the next DECODE.
REQ-033 sensor_done or tx_done outside their wait states SHALL be ignored.

Reset
REQ-034 On reset low: state IDLE, all outputs 0, continuous flag clear, all counters 0; a transfer in flight is abandoned.
REQ-035 After reset release, the first accepted byte SHALL be on the first has_data after the release edge.

Structure
REQ-036 Package digital_sensor_pkg SHALL hold command codes, response codes and the state encoding.
REQ-037 One sub-module, command_timer (loadable down-counter, expired flag), SHALL be used for the byte, sensor and interval timeouts.

Verification (BYTE_TIMEOUT=20, SENSOR_TIMEOUT=100, INTERVAL=300)
REQ-038 Bytes 0x01,0x03; sensor_done data 0x19 error 0 -> one request, address 3, kind 0; tx 0x08 then 0x19.
REQ-039 Byte 0x02, then 25 idle cycles, then 0x00 -> first byte discarded; second frame awaits address; no tx.
REQ-040 Frame 0x02,0x01; no sensor_done -> after 100 cycles tx 0x1F,0xFF.
REQ-041 Frame 0x04,0x02; replies serviced -> repeat request every 300 idle cycles; frame 0x05,0x00 -> tx 0x0A,0x00; no further requests.
REQ-042 Frame 0x77,0x00 -> tx 0x1E,0x77; extra byte during WAIT_SENSOR -> overrun=1, cleared by next frame.
REQ-043 Reset asserted mid-WAIT_CODE -> all outputs 0 at once; next frame handled normally.
